// File: rtl/counter_event_monitor.sv
// counter_event_monitor: flags wrap/match/jump on the upstream count and queues timestamped records (match needs COUNTER_EVENT_MONITOR_MATCH_EN).
// Latency: a record raised at edge k is at the head one cycle later when the queue was empty.
// Backpressure: valid/ready drain; a full queue with no pop discards the new record and sets sticky dropped.
module counter_event_monitor #(
   parameter int Size       = 5,
   parameter int StampWidth = 16,
   parameter int Depth      = 4,
   parameter int WrapWidth  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [Size-1:0]       count,
   input  logic [Size-1:0]       compare,
   input  logic                  clear,
   output logic                  event_valid,
   input  logic                  event_ready,
   output logic [2:0]            event_flags,
   output logic [Size-1:0]       event_value,
   output logic [StampWidth-1:0] event_stamp,
   output logic [WrapWidth-1:0]  wrap_total,
   output logic                  dropped
);
   localparam int AddrWidth = $clog2(Depth);
   localparam logic [Size-1:0]       CountOne = Size'(1);
   localparam logic [StampWidth-1:0] StampOne = StampWidth'(1);
   localparam logic [WrapWidth-1:0]  WrapOne  = WrapWidth'(1);
   localparam logic [AddrWidth:0]    PtrOne   = (AddrWidth+1)'(1);

   typedef struct packed {
      logic [2:0]            flags;
      logic [Size-1:0]       value;
      logic [StampWidth-1:0] stamp;
   } rec_t;

   logic [StampWidth-1:0] stamp;
   logic [Size-1:0]       prev_count;
   logic                  prev_valid;
   logic                  wrap_det;
   logic                  jump_det;
   logic                  match_det;
   logic                  push_vld;
   rec_t                  push_dat;
   rec_t                  head_dat;

   rec_t                  mem [Depth];
   logic [AddrWidth:0]    wr_ptr;
   logic [AddrWidth:0]    rd_ptr;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  pop;
   logic                  do_write;

   // prev_valid gates everything so the first edge after reset only primes prev_count.
   assign wrap_det = prev_valid && (prev_count == '1) && (count == '0);
   assign jump_det = prev_valid && (count != prev_count) && (count != prev_count + CountOne);

`ifdef COUNTER_EVENT_MONITOR_MATCH_EN
   assign match_det = prev_valid && (count == compare) && (count != prev_count);
`else
   logic unused_compare;
   assign unused_compare = ^compare;
   assign match_det      = 1'b0;
`endif

   always_comb begin
      push_dat       = '0;
      push_dat.flags = {jump_det, match_det, wrap_det};
      push_dat.value = count;
      push_dat.stamp = stamp;
      push_vld       = wrap_det || jump_det || match_det;
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                       (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
   assign pop        = !fifo_empty && event_ready;
   // A pop frees the head slot at the same edge, so a full queue still accepts the push.
   assign do_write   = push_vld && (!fifo_full || pop);

   assign head_dat    = mem[rd_ptr[AddrWidth-1:0]];
   assign event_valid = !fifo_empty;
   assign event_flags = head_dat.flags;
   assign event_value = head_dat.value;
   assign event_stamp = head_dat.stamp;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stamp      <= '0;
         prev_count <= '0;
         prev_valid <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wrap_total <= '0;
         dropped    <= 1'b0;
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
      end else begin
         stamp      <= stamp + StampOne;
         prev_count <= count;
         prev_valid <= 1'b1;

         if (do_write) begin
            mem[wr_ptr[AddrWidth-1:0]] <= push_dat;
            wr_ptr                     <= wr_ptr + PtrOne;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrOne;
         end

         if (clear) begin
            wrap_total <= '0;
         end else if (wrap_det && (wrap_total != '1)) begin
            wrap_total <= wrap_total + WrapOne;
         end

         if (clear) begin
            dropped <= 1'b0;
         end else if (push_vld && !do_write) begin
            dropped <= 1'b1;
         end
      end
   end

endmodule

// File: doc/counter_event_monitor.md
Name: counter_event_monitor

Overview:
- Downstream consumer of the counter design's count output.
- Watches the free-running count every clock and detects three events: wrap (31->0 at Size=5), match against a programmable compare value, and jump (any non-increment discontinuity).
- Queues timestamped event records in a small FIFO, drained by a valid/ready consumer. In the bench, the consumer is the Ruby-VPI side polling on each relay.

Parameters:
- Size, 5, width of count and compare; must equal the upstream counter's Size.
- StampWidth, 16, width of the free-running cycle timestamp.
- Depth, 4, FIFO entries; power of two, >= 2.
- WrapWidth, 8, width of the saturating wrap tally.

Ports:
- clock  input  1  design clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- count  input  Size  count from upstream counter.
- compare  input  Size  match value; may change any cycle.
- clear  input  1  synchronous clear of dropped and wrap_total.
- event_valid  output  1  FIFO head record available.
- event_ready  input  1  consumer accepts head when event_valid && event_ready.
- event_flags  output  3  head record flags {jump, match, wrap}.
- event_value  output  Size  count value that raised the event.
- event_stamp  output  StampWidth  stamp at detection.
- wrap_total  output  WrapWidth  wrap events seen, saturating.
- dropped  output  1  sticky: a record was lost to a full FIFO.

Behaviour:
- Reset values:
  - event_valid=0; event_flags, event_value, event_stamp = 0; wrap_total=0; dropped=0.
  - Internal: stamp=0, prev_count=0, prev_valid=0, FIFO empty.
- Each rising edge k: stamp increments modulo 2^StampWidth; prev_count<=count; prev_valid<=1.
- Detection is combinational on count vs prev_count, qualified by prev_valid. The first edge after reset only primes and raises no event.
  - wrap: prev_count==all-ones && count==0.
  - jump: count != prev_count && count != prev_count+1 (mod 2^Size). Mutually exclusive with wrap.
  - match: count==compare && count != prev_count. A stalled count raises match once only.
- Record write:
  - Any flag set at edge k writes one record {flags, count, stamp-before-increment} at edge k.
  - event_valid rises in the cycle after edge k, giving 1-cycle latency when the FIFO was empty.
  - Multiple flags share one record.
- FIFO:
  - First-word-fall-through; head outputs are stable while event_valid && !event_ready.
  - Pop on event_valid && event_ready.
  - Full with push and no pop: new record discarded, dropped<=1, existing entries untouched.
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty with push: event_ready is ignored that cycle, because event_valid is still 0.
- wrap_total:
  - Increments on each wrap event and holds at all-ones.
  - The count is independent of FIFO state; dropped wraps still count.
- clear:
  - Zeroes wrap_total and dropped at the edge.
  - If a wrap or drop coincides with clear, clear wins and the result is 0.
  - FIFO contents are unaffected.
- Reset mid-operation:
  - Asserting reset empties the FIFO immediately, so event_valid falls asynchronously.
  - After reset release, the next edge primes prev_count only.
- An upstream counter reset (count forced to 0 from nonzero) reports as jump, or as wrap if the prior count was all-ones.

Optional Feature:
- Macro: COUNTER_EVENT_MONITOR_MATCH_EN.
- Defined: compare port is live and match detection operates as above.
- Undefined:
  - compare port is still present but ignored; match flag is always 0.
  - The comparator logic is not synthesized.
  - Wrap and jump behaviour are identical to the defined build.

Test Plan (Size=5, Depth=4, event_ready held 1 unless stated):
- Free-run from reset, compare=31 held -> at count 31->0 one record appears:
  - first 31 record: flags=010 (match), value=31; first wrap record: flags=001, value=0.
  - wrap_total goes 1, 2, 3 on successive wraps; stamps differ by 32.
- compare=0 -> each wrap record carries flags=011, value=0, one record per wrap.
- Hold event_ready=0 across 5 wraps with compare=31 -> 4 records retained in order, dropped=1.
  - Release ready -> 4 pops in order, then event_valid=0.
- Full FIFO, pop and new wrap on the same edge -> no drop; the 4th entry afterward is the new record.
- Force count 7->20 -> record flags=100, value=20.
  - Then counter reset 21->0 -> flags=100, value=0.
- Reset asserted mid-stream with 3 records queued -> event_valid=0 and wrap_total=0 immediately.
  - First edge after release produces no record even if count=0.
- clear coincident with a wrap, wrap_total=5 -> wrap_total=0; the record is still queued.
- Build without COUNTER_EVENT_MONITOR_MATCH_EN, compare=31 -> only wrap records appear (flags=001).
